// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - pipelined ripple-carry adder, one SEG-bit segment per stage (optional subtract: PIPE_RIPPLE_ADDER_SUB_EN)
module pipelined_ripple_adder #(
    parameter int WIDTH = 24,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             co
);

    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_param_check
        $fatal(1, "pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG");
    end

    // SEG-bit ripple of full adders; returns {carry_out, sum}
    function automatic logic [SEG:0] ripple(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c);
        logic [SEG-1:0] s;
        logic           cy;
        cy = c;
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        return {cy, s};
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Subtraction is folded into the operand on entry, so the inverted B
    // and forced carry travel with the transaction in place of a sub flag.
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    assign b_in = sub ? ~B : B;
    assign c_in = sub ? 1'b1 : ci;
`else
    assign b_in = B;
    assign c_in = ci;
`endif

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when the transaction enters stage k;
        // the lowest SEG of them are this stage's segment.
        localparam int REM_IN = WIDTH - k * SEG;

        logic                    v_src;
        logic                    c_src;
        logic [REM_IN-1:0]       a_src;
        logic [REM_IN-1:0]       b_src;
        logic [SEG:0]            seg_sum;
        logic [(k+1)*SEG-1:0]    ps_d;
        logic                    vld_q;
        logic                    cy_q;
        logic [(k+1)*SEG-1:0]    ps_q;

        if (k == 0) begin : g_head
            assign v_src = in_valid;
            assign c_src = c_in;
            assign a_src = A;
            assign b_src = b_in;
            assign ps_d  = seg_sum[SEG-1:0];
        end else begin : g_body
            assign v_src = g_stage[k-1].vld_q;
            assign c_src = g_stage[k-1].cy_q;
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign ps_d  = {seg_sum[SEG-1:0], g_stage[k-1].ps_q};
        end

        assign seg_sum = ripple(a_src[SEG-1:0], b_src[SEG-1:0], c_src);

        // Stage register: valid, carry and accumulated low sum bits; holds on stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                ps_q  <= '0;
            end else if (!stall) begin
                vld_q <= v_src;
                cy_q  <= seg_sum[SEG];
                ps_q  <= ps_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM_IN-SEG-1:0] a_q;
            logic [REM_IN-SEG-1:0] b_q;

            // Unconsumed upper operand bits ride along to the next stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_src[REM_IN-1:SEG];
                    b_q <= b_src[REM_IN-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign SUM       = g_stage[STAGES-1].ps_q;
    assign co        = g_stage[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - scoreboard testbench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

    localparam int W      = 24;
    localparam int SEG    = 4;
    localparam int STAGES = W / SEG;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] SUM;
    logic         co;

    logic         in_valid12 = 1'b0;
    logic         in_ready12;
    logic [11:0]  a12 = '0;
    logic [11:0]  b12 = '0;
    logic         ci12 = 1'b0;
    logic         out_valid12;
    logic [11:0]  sum12;
    logic         co12;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops = 0;
    logic [W:0]   sb[$];
    logic [W:0]   exp_word;
    bit           rand_done;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(W), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ci(ci),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .SUM(SUM), .co(co)
    );

    pipelined_ripple_adder #(.WIDTH(12), .SEG(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
        .A(a12), .B(b12), .ci(ci12),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(out_valid12), .out_ready(1'b1), .SUM(sum12), .co(co12)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (HAS_SUB && s) return {1'b0, a} + {1'b0, ~b} + 25'd1;
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Scoreboard: push on acceptance, pop and compare on consumption
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("no_stale", {31'd0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    exp_word = sb.pop_front();
                    n_pops++;
                    check_eq("result", {7'd0, co, SUM}, {7'd0, exp_word});
                end else begin
                    check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check_eq("stall_hold", {7'd0, co, SUM}, {7'd0, sb[0]});
                end
            end
            if (in_valid && in_ready) sb.push_back(model(A, B, ci, sub));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int  n;
        logic rdy;
        in_valid = 1'b1;
        A = a; B = b; ci = c; sub = s;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            n++;
            @(posedge clk);
        end while (!rdy && n < 50);
        #1 in_valid = 1'b0;
        if (!rdy) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", sb.size(), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops0;

        // Reset state
        out_ready = 1'b0;
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_sum", {8'd0, SUM}, 32'd0);
        check_eq("rst_co", {31'd0, co}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple across every stage, with latency
        send(24'hFFFFFF, 24'h000000, 1'b1, 1'b0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, STAGES);
        check_eq("ripple_sum", {8'd0, SUM}, 32'd0);
        check_eq("ripple_co", {31'd0, co}, 32'd1);
        drain();

        // Single-stage instance: latency 1
        in_valid12 = 1'b1; a12 = 12'hFFF; b12 = 12'h001; ci12 = 1'b0;
        #1;
        check_eq("w12_ready", {31'd0, in_ready12}, 32'd1);
        check_eq("w12_pre_valid", {31'd0, out_valid12}, 32'd0);
        @(posedge clk);
        #1 in_valid12 = 1'b0;
        check_eq("w12_valid", {31'd0, out_valid12}, 32'd1);
        check_eq("w12_sum", {20'd0, sum12}, 32'd0);
        check_eq("w12_co", {31'd0, co12}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("w12_bubble", {31'd0, out_valid12}, 32'd0);

        // Back-to-back at full throughput
        pops0 = n_pops;
        send(24'h000001, 24'h000002, 1'b0, 1'b0);
        send(24'h800000, 24'h800000, 1'b0, 1'b0);
        send(24'h123456, 24'h654321, 1'b1, 1'b0);
        wait_out_valid();
        @(posedge clk);
        #1 check_eq("b2b_valid2", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 check_eq("b2b_valid3", {31'd0, out_valid}, 32'd1);
        drain();
        check_eq("b2b_count", n_pops - pops0, 32'd3);

        // Backpressure: hold for 4 cycles with 3 in flight
        pops0 = n_pops;
        out_ready = 1'b0;
        send(24'h00000F, 24'h000001, 1'b0, 1'b0);
        send(24'hABCDEF, 24'h111111, 1'b1, 1'b0);
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
        wait_out_valid();
        repeat (4) @(posedge clk);
        #1 check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        drain();
        check_eq("bp_count", n_pops - pops0, 32'd3);

        // Asynchronous reset with results in flight
        out_ready = 1'b0;
        send(24'h000010, 24'h000020, 1'b0, 1'b0);
        send(24'h000030, 24'h000040, 1'b0, 1'b0);
        send(24'h000050, 24'h000060, 1'b0, 1'b0);
        wait_out_valid();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_sum", {8'd0, SUM}, 32'd0);
        check_eq("mid_rst_co", {31'd0, co}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 check_eq("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        // Subtraction: borrow and no-borrow
        send(24'd5, 24'd7, 1'b0, 1'b1);
        send(24'd7, 24'd5, 1'b1, 1'b1);
        send(24'd7, 24'd5, 1'b1, 1'b0);
        drain();
`endif

        // Random traffic with random backpressure
        pops0 = n_pops;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_eq("rand_count", n_pops - pops0, 32'd20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
